// File: rtl/marian_spi_pkg.sv
// Shared SPI controller register map, sequencer state encoding and bus payload types.
package marian_spi_pkg;

   localparam int unsigned SPI_AW  = 8;
   localparam int unsigned SPI_DW  = 32;
   localparam int unsigned WORD_CW = 4;
   localparam int unsigned POLL_CW = 16;

   localparam logic [SPI_AW-1:0] SPI_REG_STATUS = 8'h00;
   localparam logic [SPI_AW-1:0] SPI_REG_CLKDIV = 8'h04;
   localparam logic [SPI_AW-1:0] SPI_REG_SPICMD = 8'h08;
   localparam logic [SPI_AW-1:0] SPI_REG_SPIADR = 8'h0C;
   localparam logic [SPI_AW-1:0] SPI_REG_SPILEN = 8'h10;
   localparam logic [SPI_AW-1:0] SPI_REG_SPIDUM = 8'h14;
   localparam logic [SPI_AW-1:0] SPI_REG_TXFIFO = 8'h20;
   localparam logic [SPI_AW-1:0] SPI_REG_RXFIFO = 8'h40;

   typedef enum logic [3:0] {
      IDLE, WR_CLKDIV, WR_ADDR, WR_LEN, WR_DUM, WR_TX, WR_CMD,
      POLL_REQ, POLL_WAIT, RX_REQ, RX_WAIT, RX_PUSH
   } seq_state_e;

   typedef struct packed {
      logic [7:0]         clkdiv;
      logic [SPI_DW-1:0]  spicmd;
      logic [SPI_DW-1:0]  addr;
      logic [SPI_DW-1:0]  len;
      logic [SPI_DW-1:0]  dummy;
      logic [WORD_CW-1:0] tx_words;
      logic [WORD_CW-1:0] rx_words;
   } spi_cmd_t;

   typedef struct packed {
      logic              req;
      logic              we;
      logic [SPI_AW-1:0] addr;
      logic [SPI_DW-1:0] wdata;
   } reg_req_t;

   // Word counts beyond the per-command limit are saturated rather than wrapped.
   function automatic logic [WORD_CW-1:0] clamp_words(input logic [WORD_CW-1:0] w,
                                                       input int unsigned max_w);
      return (32'(w) > max_w) ? WORD_CW'(max_w) : w;
   endfunction

   function automatic reg_req_t reg_wr(input logic [SPI_AW-1:0] addr, input logic [SPI_DW-1:0] data);
      return '{req: 1'b1, we: 1'b1, addr: addr, wdata: data};
   endfunction

   function automatic reg_req_t reg_rd(input logic [SPI_AW-1:0] addr);
      return '{req: 1'b1, we: 1'b0, addr: addr, wdata: '0};
   endfunction

endpackage

// File: rtl/spi_cmd_sequencer.sv
// Turns one SPI command into the register-bus write sequence, polls STATUS for
// completion and streams the RX FIFO words out.
module spi_cmd_sequencer
   import marian_spi_pkg::*;
#(
   parameter int unsigned POLL_TIMEOUT = 1024,
   parameter int unsigned MAX_WORDS    = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [7:0]         cmd_clkdiv_i,
   input  logic [SPI_DW-1:0]  cmd_spicmd_i,
   input  logic [SPI_DW-1:0]  cmd_addr_i,
   input  logic [SPI_DW-1:0]  cmd_len_i,
   input  logic [SPI_DW-1:0]  cmd_dummy_i,
   input  logic [WORD_CW-1:0] cmd_tx_words_i,
   input  logic [WORD_CW-1:0] cmd_rx_words_i,
   input  logic               tx_valid_i,
   output logic               tx_ready_o,
   input  logic [SPI_DW-1:0]  tx_data_i,
   output logic               rx_valid_o,
   input  logic               rx_ready_i,
   output logic [SPI_DW-1:0]  rx_data_o,
   output logic               reg_req_o,
   input  logic               reg_gnt_i,
   output logic               reg_we_o,
   output logic [SPI_AW-1:0]  reg_addr_o,
   output logic [SPI_DW-1:0]  reg_wdata_o,
   input  logic               reg_rvalid_i,
   input  logic [SPI_DW-1:0]  reg_rdata_i,
   output logic               done_o,
   output logic               err_o
);

   seq_state_e         state_q, state_d;
   spi_cmd_t           cmd_q, cmd_d;
   reg_req_t           req_q, req_d;
   logic [POLL_CW-1:0] poll_q, poll_d;
   logic [WORD_CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [WORD_CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [SPI_DW-1:0]  rx_data_q, rx_data_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               rx_valid_q, rx_valid_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               in_tx_c;
   logic               gnt_c;

   // TX words bypass the request register so a FIFO word is written the cycle it appears.
   assign in_tx_c     = (state_q == WR_TX);
   assign reg_req_o   = in_tx_c ? tx_valid_i : req_q.req;
   assign reg_we_o    = req_q.we;
   assign reg_addr_o  = req_q.addr;
   assign reg_wdata_o = in_tx_c ? tx_data_i : req_q.wdata;
   assign tx_ready_o  = in_tx_c & reg_gnt_i;
   assign gnt_c       = reg_req_o & reg_gnt_i;

   assign cmd_ready_o = cmd_ready_q;
   assign rx_valid_o  = rx_valid_q;
   assign rx_data_o   = rx_data_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

   // Next-state logic; registered outputs are decoded from the state being entered.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      poll_d    = poll_q;
      tx_cnt_d  = tx_cnt_q;
      rx_cnt_d  = rx_cnt_q;
      rx_data_d = rx_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      req_d     = '0;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               cmd_d.clkdiv   = cmd_clkdiv_i;
               cmd_d.spicmd   = cmd_spicmd_i;
               cmd_d.addr     = cmd_addr_i;
               cmd_d.len      = cmd_len_i;
               cmd_d.dummy    = cmd_dummy_i;
               cmd_d.tx_words = clamp_words(cmd_tx_words_i, MAX_WORDS);
               cmd_d.rx_words = clamp_words(cmd_rx_words_i, MAX_WORDS);
               tx_cnt_d       = '0;
               rx_cnt_d       = '0;
               poll_d         = '0;
               state_d        = WR_CLKDIV;
            end
         end
         WR_CLKDIV: if (gnt_c) state_d = WR_ADDR;
         WR_ADDR:   if (gnt_c) state_d = WR_LEN;
         WR_LEN:    if (gnt_c) state_d = WR_DUM;
         WR_DUM:    if (gnt_c) state_d = (cmd_q.tx_words == '0) ? WR_CMD : WR_TX;
         WR_TX: begin
            if (gnt_c) begin
               tx_cnt_d = tx_cnt_q + WORD_CW'(1);
               if (tx_cnt_d == cmd_q.tx_words) state_d = WR_CMD;
            end
         end
         WR_CMD: begin
            if (gnt_c) begin
               poll_d  = '0;
               state_d = POLL_REQ;
            end
         end
         POLL_REQ: if (gnt_c) state_d = POLL_WAIT;
         POLL_WAIT: begin
            if (reg_rvalid_i) begin
               if (reg_rdata_i[0]) begin
                  if (cmd_q.rx_words == '0) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = RX_REQ;
                  end
               end else if ((32'(poll_q) + 32'd1) >= POLL_TIMEOUT) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  poll_d  = poll_q + POLL_CW'(1);
                  state_d = POLL_REQ;
               end
            end
         end
         RX_REQ: if (gnt_c) state_d = RX_WAIT;
         RX_WAIT: begin
            if (reg_rvalid_i) begin
               rx_data_d = reg_rdata_i;
               state_d   = RX_PUSH;
            end
         end
         RX_PUSH: begin
            if (rx_ready_i) begin
               rx_cnt_d = rx_cnt_q + WORD_CW'(1);
               if (rx_cnt_d == cmd_q.rx_words) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = RX_REQ;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         WR_CLKDIV: req_d = reg_wr(SPI_REG_CLKDIV, {24'h0, cmd_d.clkdiv});
         WR_ADDR:   req_d = reg_wr(SPI_REG_SPIADR, cmd_d.addr);
         WR_LEN:    req_d = reg_wr(SPI_REG_SPILEN, cmd_d.len);
         WR_DUM:    req_d = reg_wr(SPI_REG_SPIDUM, cmd_d.dummy);
         WR_TX:     req_d = '{req: 1'b0, we: 1'b1, addr: SPI_REG_TXFIFO, wdata: '0};
         WR_CMD:    req_d = reg_wr(SPI_REG_SPICMD, cmd_d.spicmd);
         POLL_REQ:  req_d = reg_rd(SPI_REG_STATUS);
         RX_REQ:    req_d = reg_rd(SPI_REG_RXFIFO);
         default:   req_d = '0;
      endcase

      cmd_ready_d = (state_d == IDLE);
      rx_valid_d  = (state_d == RX_PUSH);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         req_q       <= '0;
         poll_q      <= '0;
         tx_cnt_q    <= '0;
         rx_cnt_q    <= '0;
         rx_data_q   <= '0;
         cmd_ready_q <= 1'b1;
         rx_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         req_q       <= req_d;
         poll_q      <= poll_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_data_q   <= rx_data_d;
         cmd_ready_q <= cmd_ready_d;
         rx_valid_q  <= rx_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have parameter POLL_TIMEOUT, default 1024, max STATUS polls before error.
REQ-002 SHALL have parameter MAX_WORDS, default 8, max TX and max RX words per command.
REQ-003 SHALL have port clk_i  in  1  sole clock.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid_i in 1 / cmd_ready_o out 1, command handshake.
REQ-006 SHALL have ports cmd_clkdiv_i in 8, cmd_spicmd_i in 32, cmd_addr_i in 32, cmd_len_i in 32, cmd_dummy_i in 32, SPI register values.
REQ-007 SHALL have ports cmd_tx_words_i in 4 and cmd_rx_words_i in 4, word counts 0..MAX_WORDS.
REQ-008 SHALL have ports tx_valid_i in 1, tx_ready_o out 1, tx_data_i in 32, TX word stream.
REQ-009 SHALL have ports rx_valid_o out 1, rx_ready_i in 1, rx_data_o out 32, RX word stream.
REQ-010 SHALL have ports reg_req_o out 1, reg_gnt_i in 1, reg_we_o out 1, reg_addr_o out 8, reg_wdata_o out 32, SPI register-bus request.
REQ-011 SHALL have ports reg_rvalid_i in 1, reg_rdata_i in 32, read response.
REQ-012 SHALL have ports done_o out 1, err_o out 1, single-cycle completion/timeout pulses.

Function
REQ-013 SHALL be in IDLE with cmd_ready_o=1 only there; a cmd_valid_i&cmd_ready_o cycle registers all cmd_* fields.
REQ-014 SHALL sequence writes: CLKDIV(0x04)={24'b0,clkdiv}, SPIADR(0x0C), SPILEN(0x10), SPIDUM(0x14), then tx_words writes to TXFIFO(0x20), then SPICMD(0x08).
REQ-015 SHALL hold reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o stable until the reg_gnt_i cycle; next request no earlier than the following cycle.
REQ-016 SHALL, in WR_TX, drive reg_req_o=tx_valid_i, reg_wdata_o=tx_data_i, tx_ready_o=reg_gnt_i; tx_ready_o=0 elsewhere.
REQ-017 SHALL skip WR_TX when tx_words=0 and skip RD_RX when rx_words=0; counts above MAX_WORDS are clamped to MAX_WORDS.
REQ-018 SHALL, after SPICMD grant, issue reads of STATUS(0x00), one outstanding, waiting reg_rvalid_i (>=1 cycle after grant).
REQ-019 SHALL treat reg_rdata_i[0]=1 as transfer complete; otherwise re-poll next cycle and increment poll counter.
REQ-020 SHALL, when poll counter reaches POLL_TIMEOUT without completion, pulse err_o, skip RX, return to IDLE.
REQ-021 SHALL, on completion, read RXFIFO(0x40) rx_words times; each rdata is registered and presented with rx_valid_o=1 until rx_ready_i, then next read issued.
REQ-022 SHALL pulse done_o one cycle after final RX handshake (or STATUS completion if rx_words=0), returning to IDLE same cycle.
REQ-023 SHALL implement states IDLE, WR_CLKDIV, WR_ADDR, WR_LEN, WR_DUM, WR_TX, WR_CMD, POLL_REQ, POLL_WAIT, RX_REQ, RX_WAIT, RX_PUSH.
REQ-024 SHALL ignore reg_rvalid_i when no read is outstanding and ignore cmd_valid_i outside IDLE.
REQ-025 SHALL keep done_o and err_o mutually exclusive.

Reset
REQ-026 SHALL, on rst_ni low at any time, asynchronously enter IDLE and clear counters and captured fields.
REQ-027 SHALL reset outputs: cmd_ready_o=1, reg_req_o=0, reg_we_o=0, reg_addr_o=0, reg_wdata_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0, done_o=0, err_o=0.
REQ-028 SHALL, if reset mid-command, drop reg_req_o without completing the pending access; no done_o/err_o.

Structure
REQ-029 SHALL take SPI register offsets (SPI_REG_STATUS..SPI_REG_RXFIFO) and the state enum from shared package marian_spi_pkg.
REQ-030 SHALL be a single module with no sub-modules; poll counter 16 bits, word counters 4 bits.

Verification
REQ-031 SHALL check cmd clkdiv=0x03, tx=2, rx=0, grant always, STATUS=1 first poll -> writes 0x04,0x0C,0x10,0x14,0x20,0x20,0x08 in order, one read 0x00, done_o pulse.
REQ-032 SHALL check tx=0, rx=3, RXFIFO data 0xA,0xB,0xC with rx_ready_i low 2 cycles each -> rx_data_o 0xA,0xB,0xC in order, held stable, done_o after third.
REQ-033 SHALL check STATUS always 0, POLL_TIMEOUT=4 -> exactly 4 STATUS reads, err_o pulse, no RXFIFO read, cmd_ready_o=1 next cycle.
REQ-034 SHALL check reg_gnt_i withheld 5 cycles per write and tx_valid_i gapped -> request fields stable, no TX word lost or duplicated.
REQ-035 SHALL check rst_ni asserted during POLL_WAIT -> all outputs at reset values immediately; new command then completes normally.
